div16_8_seq: RTL and testbench

Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, producing a 16-bit quotient and an 8-bit remainder. This block is the inverse path to the team's 8x8 multiplier datapath. It recovers an operand from a product in the same arithmetic subsystem, and a bench can use it for round-trip error checks against the approximate multipliers. The block resolves one quotient bit per cycle and uses valid/ready handshakes on both input and output.

---
 rtl/div16_8_seq_if.sv | 29 ++
 rtl/div16_8_seq.sv | 72 +++++++
 tb/tb_div16_8_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div16_8_seq_if.sv
// div16_8_seq_if: operand/result valid-ready bundle for div16_8_seq.
// The rem signal exists only when DIV_REMAINDER_EN is defined.
interface div16_8_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quot;
`ifdef DIV_REMAINDER_EN
   logic [7:0]  rem;
`endif
   logic        div_by_zero;
   modport master (
      output in_valid, dividend, divisor, out_ready,
`ifdef DIV_REMAINDER_EN
      input  rem,
`endif
      input  in_ready, out_valid, quot, div_by_zero
   );
   modport slave (
      input  in_valid, dividend, divisor, out_ready,
`ifdef DIV_REMAINDER_EN
      output rem,
`endif
      output in_ready, out_valid, quot, div_by_zero
   );
endinterface

// File: rtl/div16_8_seq.sv
// div16_8_seq: sequential restoring divider, 16-bit / 8-bit unsigned, one quotient bit per cycle.
// Define DIV_REMAINDER_EN to expose the 8-bit remainder on the bus.
module div16_8_seq (
   input logic          clk,
   input logic          rst,
   div16_8_seq_if.slave bus_if
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t      state_q, state_d;
   logic [15:0] q_q, q_d;
   logic [7:0]  r_q, r_d, d_q, d_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dbz_q, dbz_d;
   logic [8:0]  t;
   logic        ge;
   // r_q < d_q holds between iterations, so t - d always fits in 8 bits
   assign t  = {r_q, q_q[15]};
   assign ge = t >= {1'b0, d_q};
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: if (bus_if.in_valid) begin
            cnt_d   = 4'd0;
            d_d     = bus_if.divisor;
            dbz_d   = bus_if.divisor == 8'd0;
            q_d     = dbz_d ? 16'hFFFF : bus_if.dividend;
            r_d     = dbz_d ? bus_if.dividend[7:0] : 8'd0;
            state_d = dbz_d ? DONE : CALC;
         end
         CALC: begin
            q_d     = {q_q[14:0], ge};
            r_d     = ge ? t[7:0] - d_q : t[7:0];
            cnt_d   = cnt_q + 4'd1;
            state_d = cnt_q == 4'd15 ? DONE : CALC;
         end
         DONE: if (bus_if.out_ready) begin
            state_d = IDLE;
            dbz_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end
   assign bus_if.in_ready    = state_q == IDLE;
   assign bus_if.out_valid   = state_q == DONE;
   assign bus_if.quot        = q_q;
   assign bus_if.div_by_zero = dbz_q;
`ifdef DIV_REMAINDER_EN
   assign bus_if.rem         = r_q;
`endif
endmodule

// File: tb/tb_div16_8_seq.sv
// tb_div16_8_seq: directed + random scoreboard bench for div16_8_seq (rem checks only with DIV_REMAINDER_EN).
module tb_div16_8_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;
   typedef struct packed {logic [15:0] q; logic [7:0] r; logic z;} exp_t;
   exp_t sb[$];
   div16_8_seq_if bus();
   div16_8_seq u_dut (.clk(clk), .rst(rst), .bus_if(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_assert++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      check({tag, "_quot"}, 32'(bus.quot), 0);
`ifdef DIV_REMAINDER_EN
      check({tag, "_rem"}, 32'(bus.rem), 0);
`endif
      check({tag, "_dbz"}, 32'(bus.div_by_zero), 0);
   endtask

   // Returns at cycle 1 relative to the accept cycle; expected result is queued at drive time.
   task automatic send(input logic [15:0] a, input logic [7:0] b);
      int w = 0;
      exp_t e;
      while (!bus.in_ready && w < 50) begin
         tick();
         w++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 1);
      if (b == 8'd0) e = '{q: 16'hFFFF, r: a[7:0], z: 1'b1};
      else e = '{q: a / {8'd0, b}, r: 8'(a % {8'd0, b}), z: 1'b0};
      sb.push_back(e);
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic get_result(input int lat_req);
      int lat = 1;
      exp_t e = '0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(lat_req));
      check("out_valid", 32'(bus.out_valid), 1);
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) e = sb.pop_front();
      check("quot", 32'(bus.quot), 32'(e.q));
`ifdef DIV_REMAINDER_EN
      check("rem", 32'(bus.rem), 32'(e.r));
`endif
      check("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      tick();
      check("in_ready_after", 32'(bus.in_ready), 1);
      check("out_valid_after", 32'(bus.out_valid), 0);
   endtask

   initial begin
      logic [15:0] ea [4] = '{16'd65535, 16'd65535, 16'd0, 16'd254};
      logic [7:0]  eb [4] = '{8'd1, 8'd255, 8'd5, 8'd255};
      logic        seen;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();
      send(16'd1000, 8'd7);
      get_result(17);
      check("quot_1000_7", 32'(bus.quot), 142);
`ifdef DIV_REMAINDER_EN
      check("rem_1000_7", 32'(bus.rem), 6);
`endif
      release_out();
      for (int i = 0; i < 4; i++) begin
         send(ea[i], eb[i]);
         get_result(17);
         release_out();
      end
      send(16'd100, 8'd0);
      get_result(1);
      check("quot_dbz", 32'(bus.quot), 32'hFFFF);
      release_out();
      check("dbz_cleared", 32'(bus.div_by_zero), 0);
      send(16'd9, 8'd3);
      get_result(17);
      release_out();
      // Backpressure: result must hold while stray operands are offered
      bus.out_ready = 1'b0;
      send(16'd50000, 8'd123);
      get_result(17);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = (i == 3 || i == 6);
         bus.dividend = 16'd7;
         bus.divisor  = 8'd7;
         tick();
         bus.in_valid = 1'b0;
         check("bp_quot", 32'(bus.quot), 406);
`ifdef DIV_REMAINDER_EN
         check("bp_rem", 32'(bus.rem), 62);
`endif
         check("bp_out_valid", 32'(bus.out_valid), 1);
         check("bp_in_ready", 32'(bus.in_ready), 0);
      end
      release_out();
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen |= bus.out_valid;
      end
      check("bp_no_stray", 32'(seen), 0);
      // Reset during CALC abandons the operation
      send(16'd40000, 8'd3);
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("midrst");
      if (sb.size() != 0) void'(sb.pop_back());
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen |= bus.out_valid;
      end
      check("midrst_no_result", 32'(seen), 0);
      send(16'd40000, 8'd3);
      get_result(17);
      check("quot_40000_3", 32'(bus.quot), 13333);
      release_out();
      for (int i = 0; i < 300; i++) begin
         logic [15:0] a;
         logic [7:0]  b;
         a = 16'($urandom);
         b = 8'($urandom_range(1, 255));
         send(a, b);
         get_result(17);
`ifdef DIV_REMAINDER_EN
         check("rnd_identity", 32'(bus.quot) * 32'(b) + 32'(bus.rem), 32'(a));
         check("rnd_rem_lt", 32'(bus.rem < b), 1);
`endif
         release_out();
      end
      check("sb_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
